alu_acc_ctrl: RTL
=================

Name: alu_acc_ctrl

Overview:
Execution controller that sits directly upstream and downstream of the 4-bit ALU.
- Accepts one instruction (3-bit ALU command + 4-bit immediate) per valid/ready handshake.
- Drives the ALU's A operand from its internal accumulator and its B operand from the immediate.
- Writes the ALU result back into the accumulator and keeps the carry/zero flags for the rest of the datapath.
- The ALU itself is purely combinational; this block supplies all of the sequencing.

Parameters:
DATA_W, 4, accumulator/operand/result width; must match the ALU width.
CNT_W, 8, width of the retire counter; used only with the optional feature.

Ports:
clk  input  1  single system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction present on instr_cmd/instr_imm
instr_ready  output  1  block can accept an instruction this cycle
instr_cmd  input  3  ALU command: 000 pass A, 001 compare (A-B), 010 pass B, 011 add, 100 nand
instr_imm  input  DATA_W  immediate operand, becomes ALU B
alu_a  output  DATA_W  to ALU A; always equals acc
alu_b  output  DATA_W  to ALU B; registered immediate
alu_cmd  output  3  to ALU command; registered
alu_result  input  DATA_W  from ALU result
alu_carry  input  1  from ALU carry
alu_zero  input  1  from ALU zero ("exit") output
acc  output  DATA_W  accumulator
flag_c  output  1  carry/borrow flag
flag_z  output  1  zero flag
done  output  1  one-cycle pulse when an instruction retires
err_illegal  output  1  one-cycle pulse with done for command 101/110/111

Behaviour:
Reset (reset_n low, asynchronous):
- State goes to IDLE.
- acc, flag_c, flag_z, done, err_illegal, instr_ready are all 0.
- alu_b is 0 and alu_cmd is 000.
- Any in-flight instruction is discarded.
- instr_ready rises at the first clk edge after reset_n is released.

State machine IDLE -> EXEC -> WB -> IDLE:
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge T, register instr_cmd into alu_cmd and instr_imm into alu_b, then go to EXEC.
  - instr_ready drops to 0 after edge T.
- EXEC: one settle cycle for the combinational ALU; go to WB.
- WB: at the edge that leaves WB (T+2), apply the writeback rules below and go to IDLE.
  - done=1 for exactly the cycle after T+2.
  - instr_ready=1 in that same cycle, so back-to-back throughput is 1 instruction per 3 cycles.
- In IDLE, alu_cmd returns to 000 at edge T+2. alu_b holds its last value.
- instr_valid is ignored while instr_ready=0; no queuing.

Writeback rules at edge T+2:
- 000 pass A: acc unchanged; flags unchanged.
- 001 compare: acc unchanged; flag_c=alu_carry (borrow, 5-bit result bit 4); flag_z=alu_zero.
- 010 pass B: acc=alu_result; flags unchanged.
- 011 add: acc=alu_result (mod 2^DATA_W); flag_c=alu_carry; flag_z=alu_zero.
- 100 nand: acc=alu_result; flags unchanged.
- 101/110/111: no acc or flag write; err_illegal=1 together with done.

Boundary behaviour:
- The accumulator wraps silently: F+1 gives 0 with C=1. flag_z reflects the full 5-bit ALU result, so F+1 gives Z=0.
- Reset asserted during EXEC or WB: no writeback, no done pulse.
- Simultaneous instr_valid and done in the same cycle: the new instruction is accepted at that edge.

Optional Feature:
Macro ALU_ACC_RETIRE_CNT_EN.
- Defined: adds output instr_count [CNT_W-1:0].
  - Reset to 0.
  - Increments by 1 at each edge where done is asserted, including illegal commands.
  - Wraps 2^CNT_W-1 -> 0 without a flag.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then 010/imm 5 -> acc=5 at T+2; done pulses one cycle; flags 0/0; instr_ready low for exactly 2 cycles after accept.
- acc=5, 011/imm C -> acc=1, flag_c=1, flag_z=0. Then 001/imm 1 -> acc stays 1, flag_c=0, flag_z=1.
- acc=1, 001/imm 2 -> borrow: flag_c=1, flag_z=0, acc=1. Then 100/imm F -> acc=E, flags unchanged (1/0).
- 110/imm 3 -> done and err_illegal pulse together; acc and flags unchanged. With ALU_ACC_RETIRE_CNT_EN, instr_count increments; 256 retires return it to 0.
- Hold instr_valid high with alternating commands -> one accept every 3 cycles; inputs presented while busy are not captured.
- Assert reset_n low during the EXEC of 011/imm 7 -> acc=0, flags 0, no done; instr_ready=1 one edge after release.

Source files
------------

// File: rtl/alu_acc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_acc_ctrl                                                    |
// | Purpose  : Execution controller wrapped around a purely combinational      |
// |            ALU. Accepts one instruction (command + immediate) per          |
// |            valid/ready handshake, sequences IDLE -> EXEC -> WB, and writes |
// |            the ALU result and carry/zero flags back.                       |
// | Ports    : clk, reset_n (async, active-low)                                |
// |            instr_valid/instr_ready/instr_cmd/instr_imm : instruction input |
// |            alu_a/alu_b/alu_cmd   : operands/command driven to the ALU      |
// |            alu_result/alu_carry/alu_zero : ALU response                    |
// |            acc/flag_c/flag_z     : architectural state                     |
// |            done/err_illegal      : one-cycle retire / illegal-cmd pulses   |
// |            instr_count           : retire counter (ALU_ACC_RETIRE_CNT_EN)  |
// | Options  : define ALU_ACC_RETIRE_CNT_EN to add the CNT_W retire counter.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_acc_ctrl #(
  parameter int DATA_W = 4
`ifdef ALU_ACC_RETIRE_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_cmd,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_cmd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] acc,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done,
  output logic              err_illegal
`ifdef ALU_ACC_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] instr_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] CMD_PASS_A  = 3'b000;
  localparam logic [2:0] CMD_COMPARE = 3'b001;
  localparam logic [2:0] CMD_PASS_B  = 3'b010;
  localparam logic [2:0] CMD_ADD     = 3'b011;
  localparam logic [2:0] CMD_NAND    = 3'b100;

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              fc_q, fc_d;
  logic              fz_q, fz_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept_w;

  // ready is a register, so it stays low in the cycle right after reset
  // release and only rises on the first clock edge.
  assign accept_w = instr_valid & ready_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = accept_w ? S_EXEC : S_IDLE;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    acc_d   = acc_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    cmd_d   = cmd_q;
    b_d     = b_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = (state_d == S_IDLE);

    if ((state_q == S_IDLE) && accept_w) begin
      cmd_d = instr_cmd;
      b_d   = instr_imm;
    end

    if (state_q == S_WB) begin
      done_d = 1'b1;
      cmd_d  = CMD_PASS_A;
      case (cmd_q)
        CMD_PASS_A: ;
        CMD_COMPARE: begin
          fc_d = alu_carry;
          fz_d = alu_zero;
        end
        CMD_PASS_B: acc_d = alu_result;
        CMD_ADD: begin
          acc_d = alu_result;
          fc_d  = alu_carry;
          fz_d  = alu_zero;
        end
        CMD_NAND: acc_d = alu_result;
        default:  err_d = 1'b1;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      cmd_q   <= CMD_PASS_A;
      b_q     <= '0;
      acc_q   <= '0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      cmd_q   <= cmd_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_a       = acc_q;
  assign alu_b       = b_q;
  assign alu_cmd     = cmd_q;
  assign acc         = acc_q;
  assign flag_c      = fc_q;
  assign flag_z      = fz_q;
  assign done        = done_q;
  assign err_illegal = err_q;

`ifdef ALU_ACC_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts every retire, illegal commands included; wraps silently.
  assign cnt_d = done_q ? (cnt_q + CNT_W'(1)) : cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
`endif

endmodule

`default_nettype wire
